// File: rtl/usb_nrzi_stuff_encoder.sv
// USB transmit line encoder: NRZI with bit stuffing, per-bit slot timer and
// autonomous EOP (SE0 slots followed by one J slot).
module usb_nrzi_stuff_encoder #(
  parameter int unsigned BIT_PERIOD   = 8,
  parameter int unsigned STUFF_LEN    = 6,
  parameter int unsigned EOP_SE0_BITS = 2,
  parameter int unsigned LOW_SPEED    = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_valid,
  input  logic bit_data,
  output logic bit_ready,
  input  logic eop_req,
  output logic d_plus,
  output logic d_minus,
  output logic busy,
  output logic eop_done,
  output logic underrun
);
  localparam int unsigned TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int unsigned OW = $clog2(STUFF_LEN + 1);
  localparam int unsigned SW = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(BIT_PERIOD - 1);
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);
  localparam logic [SW-1:0] SE0_LAST = SW'(EOP_SE0_BITS - 1);
  localparam logic [1:0]    LINE_J   = (LOW_SPEED != 0) ? 2'b01 : 2'b10;
  localparam logic [1:0]    LINE_K   = ~LINE_J;

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_STUFF, S_SE0, S_EOP_J} state_t;

  state_t        r_state;
  logic [TW-1:0] r_tmr;
  logic [OW-1:0] r_ones;
  logic [SW-1:0] r_se0;
  logic          r_lvl_j;
  logic [1:0]    r_line;

  logic w_slot_end;
  logic w_data_slot;
  logic w_stuff_due;
  logic w_take;
  logic w_tx_lvl;

  function automatic logic [1:0] line_of(input logic is_j);
    return is_j ? LINE_J : LINE_K;
  endfunction

  assign w_slot_end  = (r_state != S_IDLE) && (r_tmr == TMR_LAST);
  assign w_data_slot = (r_state == S_DATA) || (r_state == S_STUFF);
  assign w_stuff_due = (r_ones == ONES_MAX);
  // A data 0 toggles the line level, a data 1 holds it.
  assign w_tx_lvl    = bit_data ? r_lvl_j : !r_lvl_j;

  assign bit_ready = !rst && ((r_state == S_IDLE) ||
                              (w_data_slot && w_slot_end && !w_stuff_due));
  assign w_take    = bit_valid && bit_ready;
  assign underrun  = !rst && w_data_slot && w_slot_end && !w_stuff_due &&
                     !bit_valid && !eop_req;
  assign eop_done  = !rst && (r_state == S_EOP_J) && w_slot_end;
  assign busy      = (r_state != S_IDLE);
  assign d_plus    = r_line[1];
  assign d_minus   = r_line[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_ones  <= '0;
      r_se0   <= '0;
      r_lvl_j <= 1'b1;
      r_line  <= LINE_J;
    end else begin
      if ((r_state == S_IDLE) || w_slot_end) r_tmr <= '0;
      else                                   r_tmr <= r_tmr + TW'(1);

      unique case (r_state)
        S_IDLE: begin
          r_ones <= '0;
          if (w_take) begin
            r_state <= S_DATA;
            r_lvl_j <= w_tx_lvl;
            r_line  <= line_of(w_tx_lvl);
            r_ones  <= bit_data ? OW'(1) : '0;
          end
        end
        S_DATA, S_STUFF: begin
          if (w_slot_end) begin
            // A pending stuff bit wins over both new data and EOP.
            if (w_stuff_due) begin
              r_state <= S_STUFF;
              r_ones  <= '0;
              r_lvl_j <= !r_lvl_j;
              r_line  <= line_of(!r_lvl_j);
            end else if (w_take) begin
              r_state <= S_DATA;
              r_lvl_j <= w_tx_lvl;
              r_line  <= line_of(w_tx_lvl);
              r_ones  <= bit_data ? r_ones + OW'(1) : '0;
            end else begin
              r_state <= S_SE0;
              r_se0   <= '0;
              r_line  <= 2'b00;
            end
          end
        end
        S_SE0: begin
          if (w_slot_end) begin
            if (r_se0 == SE0_LAST) begin
              r_state <= S_EOP_J;
              r_lvl_j <= 1'b1;
              r_line  <= LINE_J;
            end else begin
              r_se0 <= r_se0 + SW'(1);
            end
          end
        end
        S_EOP_J: begin
          if (w_slot_end) begin
            r_state <= S_IDLE;
            r_ones  <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_nrzi_stuff_encoder.sv
// Scoreboard bench: per-cycle expected line/handshake vectors are queued from a
// slot-level model and compared as the encoder emits them.
module tb_usb_nrzi_stuff_encoder;
  localparam int BP   = 4;
  localparam int STF  = 6;
  localparam int SE0N = 2;

  logic clk;
  logic rst, bit_valid, bit_data, eop_req;
  logic bit_ready, d_plus, d_minus, busy, eop_done, underrun;
  logic rst1, bv1, bd1, er1;
  logic rdy1, dp1, dm1, busy1, done1, und1;

  int checks   = 0;
  int failures = 0;
  logic [5:0] q0[$];

  usb_nrzi_stuff_encoder #(.BIT_PERIOD(BP), .STUFF_LEN(STF), .EOP_SE0_BITS(SE0N),
                           .LOW_SPEED(0)) dut0 (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_data(bit_data),
    .bit_ready(bit_ready), .eop_req(eop_req), .d_plus(d_plus), .d_minus(d_minus),
    .busy(busy), .eop_done(eop_done), .underrun(underrun));

  usb_nrzi_stuff_encoder #(.BIT_PERIOD(BP), .STUFF_LEN(STF), .EOP_SE0_BITS(SE0N),
                           .LOW_SPEED(1)) dut1 (
    .clk(clk), .rst(rst1), .bit_valid(bv1), .bit_data(bd1),
    .bit_ready(rdy1), .eop_req(er1), .d_plus(dp1), .d_minus(dm1),
    .busy(busy1), .eop_done(done1), .underrun(und1));

  logic [5:0] obs0, obs1;
  assign obs0 = {d_plus, d_minus, bit_ready, busy, eop_done, underrun};
  assign obs1 = {dp1, dm1, rdy1, busy1, done1, und1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int cyc, input logic [5:0] obs,
                     input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b (dp,dm,rdy,busy,done,und)",
             tag, cyc, obs, exp);
    end
  endtask

  // mode 0: underrun after data, 1: eop_req after data, 2: eop_req held throughout
  task automatic run_packet(input string tag, input logic [15:0] bits, input int n,
                            input int mode);
    int kind[$];
    logic lvq[$];
    logic lv, acc, dslot, last, nstuff, nse0;
    logic [1:0] ln;
    logic [5:0] e;
    int ones, idx, cyc;
    lv = 1'b1;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      if (!bits[i]) lv = !lv;
      kind.push_back(0);
      lvq.push_back(lv);
      ones = bits[i] ? ones + 1 : 0;
      if (ones == STF) begin
        lv = !lv;
        kind.push_back(1);
        lvq.push_back(lv);
        ones = 0;
      end
    end
    for (int i = 0; i < SE0N; i++) begin
      kind.push_back(2);
      lvq.push_back(1'b0);
    end
    kind.push_back(3);
    lvq.push_back(1'b1);

    q0.push_back(6'b10_1_000);
    for (int s = 0; s < kind.size(); s++) begin
      for (int k = 0; k < BP; k++) begin
        dslot  = (kind[s] < 2);
        last   = (k == BP - 1);
        nstuff = (s + 1 < kind.size()) && (kind[s+1] == 1);
        nse0   = (s + 1 < kind.size()) && (kind[s+1] == 2);
        if (dslot)             ln = lvq[s] ? 2'b10 : 2'b01;
        else if (kind[s] == 2) ln = 2'b00;
        else                   ln = 2'b10;
        e = {ln, dslot && last && !nstuff, 1'b1,
             (s == kind.size() - 1) && last, (mode == 0) && dslot && last && nse0};
        q0.push_back(e);
      end
    end
    q0.push_back(6'b10_1_000);

    idx = 0;
    cyc = 0;
    bit_valid = 1'b1;
    bit_data  = bits[0];
    eop_req   = (mode == 2);
    while (q0.size() > 0) begin
      @(negedge clk);
      e = q0.pop_front();
      chk(tag, cyc, obs0, e);
      acc = bit_valid && bit_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        idx++;
        if (idx < n) bit_data = bits[idx];
        else begin
          bit_valid = 1'b0;
          eop_req   = (mode != 0);
        end
      end
    end
    eop_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bit_valid = 1'b0; bit_data = 1'b0; eop_req = 1'b0;
    rst1 = 1'b1; bv1 = 1'b0; bd1 = 1'b0; er1 = 1'b0;

    @(negedge clk);
    chk("reset_fs", 0, obs0, 6'b10_0_000);
    chk("reset_ls", 0, obs1, 6'b01_0_000);
    @(posedge clk); #1;
    rst = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("post_reset_fs", 0, obs0, 6'b10_1_000);
    chk("post_reset_ls", 0, obs1, 6'b01_1_000);
    @(posedge clk); #1;

    run_packet("nrzi_010",     16'b010,   3, 1);
    run_packet("stuff_7ones",  16'h007F,  7, 1);
    run_packet("stuff_preeop", 16'h003F,  6, 2);
    run_packet("underrun",     16'b100,   3, 0);
    run_packet("mixed",        16'h0B3D, 12, 1);

    bv1 = 1'b1; bd1 = 1'b0;
    @(negedge clk);
    chk("ls_idle", 0, obs1, 6'b01_1_000);
    @(posedge clk); #1;
    bd1 = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < BP; k++) begin
        @(negedge clk);
        chk("ls_k_slots", s * BP + k, obs1, {2'b10, 1'(k == BP - 1), 3'b100});
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    chk("ls_slot3", 0, obs1, 6'b10_0_100);
    @(posedge clk); #1;
    rst1 = 1'b1; bv1 = 1'b0;
    @(negedge clk);
    chk("ls_rst_held", 0, obs1, 6'b10_0_100);
    @(posedge clk); #1;
    rst1 = 1'b0;
    for (int k = 0; k < 3 * BP; k++) begin
      @(negedge clk);
      chk("ls_after_rst", k, obs1, 6'b01_1_000);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
